// File: rtl/wide_alu_sequencer.sv
// wide_alu_sequencer: multi-byte add/subtract sequenced LSB-first through a shared 8-bit ALU
// Ports: clk/rstN (async active-low); start/isAdding/firstArg/secondArg request an op;
// busy/done/result/overflow/unsignedOverflow/isZero/sign report it;
// aluFirst/aluSecond/aluIsAdding drive the ALU, aluResult/aluUnsignedOverflow return from it.
module wide_alu_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  isAdding,
    input  logic [8*NBYTES-1:0]   firstArg,
    input  logic [8*NBYTES-1:0]   secondArg,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  overflow,
    output logic                  unsignedOverflow,
    output logic                  isZero,
    output logic                  sign,
    output logic [7:0]            aluFirst,
    output logic [7:0]            aluSecond,
    output logic                  aluIsAdding,
    input  logic [7:0]            aluResult,
    input  logic                  aluUnsignedOverflow
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [1:0] S_IDLE = 2'd0, S_BYTE = 2'd1, S_FIX = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, part_q, part_d, result_q, result_d;
    logic [IW-1:0] i_q, i_d;
    logic          op_q, op_d, pend_q, pend_d, c1_q, c1_d, done_q, done_d;
    logic          ovf_q, ovf_d, uovf_q, uovf_d, zero_q, zero_d, sign_q, sign_d;
    logic [IW+2:0] bo;
    logic          adv;
    assign bo = {i_q, 3'b000};
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        i_d         = i_q;
        pend_d      = pend_q;
        c1_d        = c1_q;
        part_d      = part_q;
        done_d      = 1'b0;
        result_d    = result_q;
        ovf_d       = ovf_q;
        uovf_d      = uovf_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        adv         = 1'b0;
        aluFirst    = 8'h00;
        aluSecond   = 8'h00;
        aluIsAdding = 1'b1;
        case (state_q)
            S_IDLE: if (start) begin
                a_d     = firstArg;
                b_d     = secondArg;
                op_d    = isAdding;
                i_d     = '0;
                pend_d  = 1'b0;
                state_d = S_BYTE;
            end
            S_BYTE: begin
                aluFirst         = a_q[bo +: 8];
                aluSecond        = b_q[bo +: 8];
                aluIsAdding      = op_q;
                part_d[bo +: 8]  = aluResult;
                c1_d             = aluUnsignedOverflow;
                // A pending carry/borrow from the lower byte forces a +/-1 correction pass
                if (pend_q) begin
                    state_d = S_FIX;
                end else begin
                    pend_d = op_q ? aluUnsignedOverflow : ~aluUnsignedOverflow;
                    adv    = 1'b1;
                end
            end
            S_FIX: begin
                aluFirst        = part_q[bo +: 8];
                aluSecond       = 8'h01;
                aluIsAdding     = op_q;
                part_d[bo +: 8] = aluResult;
                pend_d          = op_q ? (c1_q | aluUnsignedOverflow) : ~(c1_q & aluUnsignedOverflow);
                adv             = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            if (i_q == IW'(NBYTES - 1)) begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = part_d;
                uovf_d   = op_q ? pend_d : ~pend_d;
                zero_d   = (part_d == '0);
                sign_d   = part_d[W-1];
                ovf_d    = op_q ? ((a_q[W-1] & b_q[W-1] & ~part_d[W-1]) | (~a_q[W-1] & ~b_q[W-1] & part_d[W-1]))
                                : ((a_q[W-1] & ~b_q[W-1] & ~part_d[W-1]) | (~a_q[W-1] & b_q[W-1] & part_d[W-1]));
            end else begin
                i_d     = i_q + 1'b1;
                state_d = S_BYTE;
            end
        end
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            i_q      <= '0;
            pend_q   <= 1'b0;
            c1_q     <= 1'b0;
            part_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            uovf_q   <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            i_q      <= i_d;
            pend_q   <= pend_d;
            c1_q     <= c1_d;
            part_q   <= part_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            uovf_q   <= uovf_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
        end
    end
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign result           = result_q;
    assign overflow         = ovf_q;
    assign unsignedOverflow = uovf_q;
    assign isZero           = zero_q;
    assign sign             = sign_q;
endmodule

// File: tb/tb_wide_alu_sequencer.sv
// tb_wide_alu_sequencer: scoreboard bench for wide_alu_sequencer with a behavioural 8-bit ALU
module tb_wide_alu_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;
    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         uovf;
        logic         zero;
        logic         sgn;
        int           cyc;
    } exp_t;
    logic         clk = 1'b0, rstN = 1'b1, start = 1'b0, isAdding = 1'b1;
    logic [W-1:0] firstArg = '0, secondArg = '0, result;
    logic         busy, done, overflow, unsignedOverflow, isZero, sign;
    logic [7:0]   aluFirst, aluSecond, aluResult;
    logic         aluIsAdding, aluUnsignedOverflow;
    logic [8:0]   alu_sum;
    exp_t         exp_q[$];
    int           n_checks = 0, n_fail = 0;
    wide_alu_sequencer #(.NBYTES(NB)) dut (
        .clk(clk), .rstN(rstN), .start(start), .isAdding(isAdding),
        .firstArg(firstArg), .secondArg(secondArg),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .unsignedOverflow(unsignedOverflow), .isZero(isZero), .sign(sign),
        .aluFirst(aluFirst), .aluSecond(aluSecond), .aluIsAdding(aluIsAdding),
        .aluResult(aluResult), .aluUnsignedOverflow(aluUnsignedOverflow)
    );
    always #5 clk = ~clk;
    // ALU: carry-in 0 for add, 1 for subtract; carry-out means no borrow when subtracting
    assign alu_sum = aluIsAdding ? ({1'b0, aluFirst} + {1'b0, aluSecond})
                                 : ({1'b0, aluFirst} + {1'b0, ~aluSecond} + 9'd1);
    assign aluResult           = alu_sum[7:0];
    assign aluUnsignedOverflow = alu_sum[8];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic add,
                          input int cyc, input bit poke);
        exp_t         e;
        logic [W:0]   s;
        int           k;
        bit           got;
        @(negedge clk);
        start = 1'b1; firstArg = a; secondArg = b; isAdding = add;
        s      = add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} + {1'b0, ~b} + 1'b1);
        e.res  = s[W-1:0];
        e.uovf = s[W];
        e.zero = (s[W-1:0] == '0);
        e.sgn  = s[W-1];
        e.ovf  = add ? ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]))
                     : ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1]));
        e.cyc  = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_start", busy, 1);
        chk("done_pulse_ended", done, 0);
        start = 1'b0; firstArg = ~a; secondArg = $urandom; isAdding = ~add;
        got = 0; k = 0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) got = 1;
            else begin
                start = poke && (k == 1);
                if (start) begin firstArg = 32'hDEAD_BEEF; secondArg = 32'h0101_0101; end
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        e = exp_q.pop_front();
        if (got) begin
            chk("result", result, e.res);
            chk("overflow", overflow, e.ovf);
            chk("unsignedOverflow", unsignedOverflow, e.uovf);
            chk("isZero", isZero, e.zero);
            chk("sign", sign, e.sgn);
            chk("busy_at_done", busy, 0);
            chk("busy_cycles", k, e.cyc);
        end
    endtask
    initial begin
        #2 rstN = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {overflow, unsignedOverflow, isZero, sign}, 0);
        chk("rst_alu", {aluFirst, aluSecond, aluIsAdding}, 17'h00001);
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 5, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 7, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 7, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 7, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 7, 0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 4, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 4, 0);
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 5, 0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 5, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_second_done", done, 0);
            chk("start_not_queued", busy, 0);
        end
        chk("result_held", result, 32'h0000_0100);
        @(negedge clk);
        start = 1'b1; firstArg = 32'hFFFF_FFFF; secondArg = 32'h0000_0001; isAdding = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {overflow, unsignedOverflow, isZero, sign}, 0);
        chk("midrst_alu", {aluFirst, aluSecond, aluIsAdding}, 17'h00001);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done, 0);
        end
        @(negedge clk) rstN = 1'b1;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 7, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wide_alu_sequencer.md
# wide_alu_sequencer

Multi-precision add/subtract controller for the shared 8-bit ALU. It sequences that ALU byte-by-byte, least-significant byte first, to perform NBYTES×8-bit add or subtract. Because the ALU's carry-in is fixed (0 for add, 1 for subtract), the block propagates inter-byte carry or borrow with an extra correction pass through the same ALU. It sits between the execute stage and the ALU instance and owns all ALU input ports while busy.

## Interface
- NBYTES, 4, operand width in bytes; legal range 2..8.
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle.
- isAdding  in  1  1 = add, 0 = subtract (firstArg − secondArg); latched at start.
- firstArg  in  8·NBYTES  operand A; latched at start.
- secondArg  in  8·NBYTES  operand B; latched at start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- result  out  8·NBYTES  registered sum/difference, held until next accepted start.
- overflow  out  1  signed overflow of the full-width operation.
- unsignedOverflow  out  1  add: carry out of MSB; subtract: 1 = no borrow (same convention as the ALU).
- isZero  out  1  result == 0.
- sign  out  1  result MSB.
- aluFirst  out  8  to ALU firstArg.
- aluSecond  out  8  to ALU secondArg.
- aluIsAdding  out  1  to ALU isAdding.
- aluResult  in  8  from ALU result (combinational, same cycle).
- aluUnsignedOverflow  in  1  from ALU unsignedOverflow.

## Operation
- State machine: IDLE, BYTE, FIX.
- **IDLE:** ALU ports are driven aluFirst=0, aluSecond=0, aluIsAdding=1. When start=1, the block:
  - latches A, B and op;
  - sets byte index i=0 and clears pend;
  - enters BYTE.
- **BYTE:** drives A[i] and B[i] with aluIsAdding=op, and stores aluResult into partial byte i.
  - Records c1 = aluUnsignedOverflow.
  - If pend=1, goes to FIX with the same i.
  - Otherwise derives the carry: for add, pend_next=c1; for subtract, pend_next=~c1.
- **FIX:** drives partial byte i with aluSecond=8'h01 and aluIsAdding=op, i.e. +1 (add) or −1 (subtract).
  - Overwrites partial byte i with aluResult and records c2.
  - Add: pend_next = c1 | c2. Subtract: pend_next = ~(c1 & c2).
- **Advance:** after the byte completes (BYTE with pend=0, or FIX), if i < NBYTES−1 then i++ and go to BYTE. Otherwise finish.
- Byte 0 never enters FIX.
- **Finish:**
  - Register result.
  - unsignedOverflow: add = final pend; subtract = ~final pend.
  - isZero = (result == 0); sign = result MSB.
  - overflow, with a = A MSB, b = B MSB, r = result MSB:
    - add: (a & b & ~r) | (~a & ~b & r);
    - subtract: (a & ~b & ~r) | (~a & b & r).
  - Pulse done and return to IDLE.
- start while busy is ignored; it is neither queued nor re-latched.
- Inputs firstArg, secondArg and isAdding may change freely after the start cycle.

## Timing
- **Reset:** state=IDLE, busy=0, done=0, result=0, overflow=0, unsignedOverflow=0, isZero=0, sign=0, i=0, pend=0, partial bytes=0. Reset takes effect immediately, including mid-operation; the in-flight operation is discarded with no done.
- **Start:** start sampled high in IDLE at edge E0 → busy=1 from E0 until the final ALU edge.
- **Busy duration:** exactly NBYTES + F cycles, where F = number of FIX passes (0..NBYTES−1). Best case NBYTES; worst case 2·NBYTES−1.
- **Done:** done=1 and busy=0 in the cycle after the last ALU op edge. All flags and result update at that same edge.
- **Back-to-back:** a new start may be sampled in the done cycle.
- **ALU path:** combinational from state/index registers. The ALU result is captured at the edge ending each BYTE/FIX cycle.

## Test plan
- NBYTES=4, add 0x000000FF + 0x00000001 → result 0x00000100, busy 5 cycles, unsignedOverflow=0, overflow=0, isZero=0.
- Add 0xFFFFFFFF + 0x00000001 → result 0x00000000, busy 7 cycles, unsignedOverflow=1, isZero=1, overflow=0.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, sign=1, unsignedOverflow=0.
- Subtract 0x00000000 − 0x00000001 → 0xFFFFFFFF, busy 7, unsignedOverflow=0, sign=1, overflow=0.
- Subtract 0x80000000 − 0x00000001 → 0x7FFFFFFF, unsignedOverflow=1, overflow=1, sign=0, busy 7.
- Subtract 0x12345678 − 0x12345678 → 0, busy 4, isZero=1, unsignedOverflow=1.
- Control checks:
  - start pulsed mid-operation → ignored; prior result held; exactly one done.
  - rstN dropped mid-operation → all outputs 0 immediately; no done; next start completes normally.
